// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - 24-bit I2S stereo receiver, one left/right pair per frame.
// Optional slot-length checker: define I2S_RX_FRAME_CHECK_EN to add frame_err_o.
module i2s_rx_deserializer #(
   parameter int DATA_W      = 24,
   parameter int SLOT_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              bclk_i,
   input  logic              lrclk_i,
   input  logic              sdata_i,
   input  logic              devices_ready_i,
   output logic [DATA_W-1:0] left_o,
   output logic [DATA_W-1:0] right_o,
`ifdef I2S_RX_FRAME_CHECK_EN
   output logic              frame_err_o,
`endif
   output logic              valid_o
);

   localparam int IDX_W = $clog2(SLOT_W);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(SLOT_W - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W);

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        sync_q [SYNC_STAGES];
   logic              bclk_s, lrclk_s, sdata_s;
   logic              bclk_d_q, lr_prev_q;
   logic              rise, lr_edge, bit_en, word_done;
   logic              cap_left, cap_right;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d, hold_q, left_q, right_q;
   logic              valid_q;

   // All three inputs share one pipeline so their relative phase is preserved.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {bclk_i, lrclk_i, sdata_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign bclk_s  = sync_q[SYNC_STAGES-1][2];
   assign lrclk_s = sync_q[SYNC_STAGES-1][1];
   assign sdata_s = sync_q[SYNC_STAGES-1][0];

   assign rise    = bclk_s & ~bclk_d_q;
   assign lr_edge = rise & (lrclk_s ^ lr_prev_q);

   always_comb begin
      idx_d = idx_q;
      if (!devices_ready_i)
         idx_d = '0;
      else if (rise) begin
         if (lr_edge)
            idx_d = '0;
         else if (idx_q != IDX_MAX)
            idx_d = idx_q + 1'b1;
      end
   end

   // Index 0 is the one-bit I2S delay slot; data occupies indices 1..DATA_W.
   assign bit_en    = rise & devices_ready_i & ~lr_edge & (idx_d != '0) & (idx_d <= IDX_LAST);
   assign word_done = bit_en & (idx_d == IDX_LAST);

   always_comb begin
      shift_d = shift_q;
      if (!devices_ready_i || lr_edge)
         shift_d = '0;
      else if (bit_en)
         shift_d = {shift_q[DATA_W-2:0], sdata_s};
   end

   always_ff @(posedge clk_i) begin
      if (srst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!devices_ready_i)
         state_d = IDLE;
      else if (lr_edge) begin
         if (!lrclk_s)
            state_d = LEFT;
         else if (state_q != IDLE)
            state_d = RIGHT;
      end
   end

   always_comb begin
      cap_left  = 1'b0;
      cap_right = 1'b0;
      case (state_q)
         LEFT:    cap_left  = word_done;
         RIGHT:   cap_right = word_done;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         bclk_d_q  <= 1'b0;
         lr_prev_q <= 1'b0;
         idx_q     <= '0;
         shift_q   <= '0;
         hold_q    <= '0;
         left_q    <= '0;
         right_q   <= '0;
         valid_q   <= 1'b0;
      end else begin
         bclk_d_q <= bclk_s;
         if (rise) lr_prev_q <= lrclk_s;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         valid_q  <= cap_right;
         if (cap_left) hold_q <= shift_d;
         if (cap_right) begin
            left_q  <= hold_q;
            right_q <= shift_d;
         end
      end
   end

   assign left_o  = left_q;
   assign right_o = right_q;
   assign valid_o = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
   logic frame_err_q;

   // A slot that ends at any index other than SLOT_W-1 was not exactly SLOT_W BCLKs long.
   always_ff @(posedge clk_i) begin
      if (srst_i)
         frame_err_q <= 1'b0;
      else if (lr_edge && devices_ready_i && state_q != IDLE && idx_q != IDX_MAX)
         frame_err_q <= 1'b1;
   end

   assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - directed bench driving an ideal I2S source (BCLK=clk/4).
module tb_i2s_rx_deserializer;
   localparam int DATA_W = 24;
   localparam int SYNC   = 3;

   logic clk = 1'b0, srst = 1'b1, bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0, ready = 1'b0;
   logic [DATA_W-1:0] left, right;
   logic valid;
`ifdef I2S_RX_FRAME_CHECK_EN
   logic ferr;
`endif

   i2s_rx_deserializer #(.DATA_W(DATA_W), .SLOT_W(32), .SYNC_STAGES(SYNC)) dut (
      .clk_i(clk), .srst_i(srst), .bclk_i(bclk), .lrclk_i(lrclk), .sdata_i(sdata),
      .devices_ready_i(ready), .left_o(left), .right_o(right),
`ifdef I2S_RX_FRAME_CHECK_EN
      .frame_err_o(ferr),
`endif
      .valid_o(valid));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, passed = 0;
   int vcnt = 0, vcyc = 0, vprev_cyc = 0, dbl = 0;
   logic [DATA_W-1:0] vl = '0, vr = '0;
   logic vlast = 1'b0;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (vlast) dbl++;
         vcnt++;
         vprev_cyc = vcyc;
         vcyc = cyc;
         vl = left;
         vr = right;
      end
      vlast = (valid === 1'b1);
   end

   int last_rise_cyc = 0, cap_cyc = 0;
   logic prev_lsb = 1'b0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic lr, input logic d);
      bclk = 1'b0; lrclk = lr; sdata = d;
      tick(2);
      bclk = 1'b1;
      last_rise_cyc = cyc;
      tick(2);
   endtask

   task automatic drive_slot(input logic lr, input logic [DATA_W-1:0] w, input int j0, input int j1);
      logic d;
      for (int j = j0; j < j1; j++) begin
         if (j == 0) d = prev_lsb;
         else if (j <= DATA_W) d = w[DATA_W-j];
         else d = 1'b0;
         drive_bit(lr, d);
         if (j == DATA_W) cap_cyc = last_rise_cyc;
      end
      prev_lsb = w[0];
   endtask

   task automatic drive_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      drive_slot(1'b0, l, 0, 32);
      drive_slot(1'b1, r, 0, 32);
   endtask

   task automatic test_reset;
      srst = 1'b1;
      tick(5);
      checks++; if (left !== 24'h0) $display("FAIL reset_left got %h exp 000000", left); else passed++;
      checks++; if (right !== 24'h0) $display("FAIL reset_right got %h exp 000000", right); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else passed++;
`ifdef I2S_RX_FRAME_CHECK_EN
      checks++; if (ferr !== 1'b0) $display("FAIL reset_ferr got %b exp 0", ferr); else passed++;
`endif
      srst = 1'b0;
   endtask

   task automatic test_nominal;
      int v0;
      ready = 1'b1;
      drive_slot(1'b1, 24'h0, 0, 32);
      v0 = vcnt;
      repeat (3) drive_frame(24'h800001, 24'h7FFFFE);
      checks++; if (vcnt - v0 != 3) $display("FAIL nom_count got %0d exp 3", vcnt - v0); else passed++;
      checks++; if (vl !== 24'h800001) $display("FAIL nom_left got %h exp 800001", vl); else passed++;
      checks++; if (vr !== 24'h7FFFFE) $display("FAIL nom_right got %h exp 7ffffe", vr); else passed++;
      checks++; if (vcyc - vprev_cyc != 256) $display("FAIL nom_period got %0d exp 256", vcyc - vprev_cyc); else passed++;
      checks++; if (vcyc - cap_cyc != SYNC + 1) $display("FAIL nom_latency got %0d exp %0d", vcyc - cap_cyc, SYNC + 1); else passed++;
   endtask

   task automatic test_startup;
      int v0;
      srst = 1'b1; tick(2); srst = 1'b0;
      ready = 1'b0;
      drive_slot(1'b1, 24'h333333, 0, 10);
      ready = 1'b1;
      v0 = vcnt;
      drive_slot(1'b1, 24'h333333, 10, 32);
      checks++; if (vcnt != v0) $display("FAIL start_early got %0d exp 0", vcnt - v0); else passed++;
      drive_frame(24'h123456, 24'hFEDCBA);
      checks++; if (vcnt - v0 != 1) $display("FAIL start_count got %0d exp 1", vcnt - v0); else passed++;
      checks++; if (vl !== 24'h123456) $display("FAIL start_left got %h exp 123456", vl); else passed++;
      checks++; if (vr !== 24'hFEDCBA) $display("FAIL start_right got %h exp fedcba", vr); else passed++;
   endtask

   task automatic test_ready_drop;
      int v0;
      drive_frame(24'h0F0F0F, 24'hF0F0F0);
      v0 = vcnt;
      drive_slot(1'b0, 24'hAAAAAA, 0, 32);
      drive_slot(1'b1, 24'h555555, 0, 10);
      ready = 1'b0;
      drive_slot(1'b1, 24'h555555, 10, 32);
      repeat (2) drive_frame(24'h111111, 24'h222222);
      drive_slot(1'b0, 24'h444444, 0, 32);
      drive_slot(1'b1, 24'h666666, 0, 10);
      ready = 1'b1;
      drive_slot(1'b1, 24'h666666, 10, 32);
      checks++; if (vcnt != v0) $display("FAIL drop_novalid got %0d exp 0", vcnt - v0); else passed++;
      checks++; if (left !== 24'h0F0F0F) $display("FAIL drop_hold_left got %h exp 0f0f0f", left); else passed++;
      checks++; if (right !== 24'hF0F0F0) $display("FAIL drop_hold_right got %h exp f0f0f0", right); else passed++;
      drive_frame(24'hC00003, 24'h3FFFFC);
      checks++; if (vcnt - v0 != 1) $display("FAIL drop_resume_count got %0d exp 1", vcnt - v0); else passed++;
      checks++; if (vl !== 24'hC00003) $display("FAIL drop_resume_left got %h exp c00003", vl); else passed++;
      checks++; if (vr !== 24'h3FFFFC) $display("FAIL drop_resume_right got %h exp 3ffffc", vr); else passed++;
   endtask

   task automatic test_reset_mid;
      int v0;
      v0 = vcnt;
      drive_slot(1'b0, 24'h987654, 0, 12);
      srst = 1'b1;
      tick(1);
      checks++; if (left !== 24'h0) $display("FAIL rmid_left got %h exp 000000", left); else passed++;
      checks++; if (right !== 24'h0) $display("FAIL rmid_right got %h exp 000000", right); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", valid); else passed++;
      srst = 1'b0;
      drive_slot(1'b0, 24'h987654, 12, 32);
      drive_slot(1'b1, 24'h010203, 0, 32);
      checks++; if (vcnt != v0) $display("FAIL rmid_novalid got %0d exp 0", vcnt - v0); else passed++;
      drive_frame(24'hABCDEF, 24'h000001);
      checks++; if (vcnt - v0 != 1) $display("FAIL rmid_count got %0d exp 1", vcnt - v0); else passed++;
      checks++; if (vl !== 24'hABCDEF) $display("FAIL rmid_left_rec got %h exp abcdef", vl); else passed++;
      checks++; if (vr !== 24'h000001) $display("FAIL rmid_right_rec got %h exp 000001", vr); else passed++;
   endtask

   task automatic test_random_extremes;
      logic [DATA_W-1:0] tbl [4];
      logic [DATA_W-1:0] l, r;
      int v0;
      tbl[0] = 24'h000000; tbl[1] = 24'hFFFFFF; tbl[2] = 24'h800000; tbl[3] = 24'h7FFFFF;
      v0 = vcnt;
      for (int f = 0; f < 100; f++) begin
         l = tbl[$urandom_range(0, 3)];
         r = tbl[$urandom_range(0, 3)];
         drive_frame(l, r);
         checks++; if (vcnt - v0 != f + 1) $display("FAIL rnd_count f%0d got %0d exp %0d", f, vcnt - v0, f + 1); else passed++;
         checks++; if (vl !== l) $display("FAIL rnd_left f%0d got %h exp %h", f, vl, l); else passed++;
         checks++; if (vr !== r) $display("FAIL rnd_right f%0d got %h exp %h", f, vr, r); else passed++;
         checks++; if (vcyc - cap_cyc != SYNC + 1) $display("FAIL rnd_latency f%0d got %0d exp %0d", f, vcyc - cap_cyc, SYNC + 1); else passed++;
      end
   endtask

`ifdef I2S_RX_FRAME_CHECK_EN
   task automatic test_frame_err;
      srst = 1'b1; tick(2); srst = 1'b0;
      drive_slot(1'b1, 24'h0, 0, 32);
      drive_frame(24'h100000, 24'h200000);
      checks++; if (ferr !== 1'b0) $display("FAIL ferr_good got %b exp 0", ferr); else passed++;
      drive_slot(1'b0, 24'h300000, 0, 32);
      drive_slot(1'b1, 24'h400000, 0, 30);
      drive_frame(24'h500000, 24'h600000);
      checks++; if (ferr !== 1'b1) $display("FAIL ferr_set got %b exp 1", ferr); else passed++;
      repeat (10) drive_frame(24'h700000, 24'h080000);
      checks++; if (ferr !== 1'b1) $display("FAIL ferr_sticky got %b exp 1", ferr); else passed++;
      srst = 1'b1; tick(1); srst = 1'b0;
      checks++; if (ferr !== 1'b0) $display("FAIL ferr_clear got %b exp 0", ferr); else passed++;
   endtask
`endif

   initial begin
      tick(1);
      test_reset();
      test_nominal();
      test_startup();
      test_ready_drop();
      test_reset_mid();
      test_random_extremes();
`ifdef I2S_RX_FRAME_CHECK_EN
      test_frame_err();
`endif
      checks++; if (dbl != 0) $display("FAIL valid_width got %0d multi-cycle pulses exp 0", dbl); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
